// File: rtl/shift_pipe.sv
// Barrel shifter pipeline (SLL/SRL/SRA/ROR), one shift-by-2^k stage per shamt bit; optional ROR via SHIFT_PIPE_ROTATE_EN.
// Latency: SHAMT_W cycles, one operation per cycle.
// Backpressure: a single global advance (!out_valid || out_ready) freezes every stage; in_ready mirrors it.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0]   dat;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    stage_t             stage_q [SHAMT_W];
    stage_t             src     [SHAMT_W];
    stage_t             nxt     [SHAMT_W];
    logic [SHAMT_W-1:0] vld_q;
    logic [SHAMT_W-1:0] src_vld;
    logic               adv;

    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             en,
        input int               k
    );
        int sh;
`ifdef SHIFT_PIPE_ROTATE_EN
        logic [2*WIDTH-1:0] dbl;
`endif
        sh = 1 << k;
        stage_shift = d;
        if (en) begin
            case (op)
                OP_SLL: stage_shift = d << sh;
                OP_SRL: stage_shift = d >> sh;
                OP_SRA: stage_shift = $signed(d) >>> sh;
                OP_ROR: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                    dbl         = {d, d} >> sh;
                    stage_shift = dbl[WIDTH-1:0];
`else
                    stage_shift = d;
`endif
                end
                default: stage_shift = d;
            endcase
        end
    endfunction

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[SHAMT_W-1];
    assign out_data  = stage_q[SHAMT_W-1].dat;
    assign out_tag   = stage_q[SHAMT_W-1].tag;
    assign busy      = |vld_q;
    assign src_vld   = {vld_q[SHAMT_W-2:0], in_valid};

    // Stage k consumes shamt bit k and clears it, so each register carries only the bits still to apply.
    always_comb begin
        src[0].dat   = in_data;
        src[0].shamt = in_shamt;
        src[0].op    = in_op;
        src[0].tag   = in_tag;
        for (int k = 1; k < SHAMT_W; k++) begin
            src[k] = stage_q[k-1];
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            nxt[k]          = src[k];
            nxt[k].dat      = stage_shift(src[k].dat, src[k].op, src[k].shamt[k], k);
            nxt[k].shamt[k] = 1'b0;
        end
    end

    // Flush kills valids only; payload registers keep their contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < SHAMT_W; k++) begin
                stage_q[k] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= src_vld;
            for (int k = 0; k < SHAMT_W; k++) begin
                if (src_vld[k]) begin
                    stage_q[k] <= nxt[k];
                end
            end
        end
    end

    logic unused_last_stage;
    assign unused_last_stage = ^{stage_q[SHAMT_W-1].shamt, stage_q[SHAMT_W-1].op};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed vectors, streaming stall, flush, mid-cycle reset, 8-bit instance.
module tb_shift_pipe;

    localparam int W       = 32;
    localparam int SW      = 5;
`ifdef SHIFT_PIPE_ROTATE_EN
    localparam bit ROT_EN  = 1'b1;
`else
    localparam bit ROT_EN  = 1'b0;
`endif

    typedef struct {
        logic [31:0] dat;
        logic [4:0]  tag;
        bit          lat_chk;
        int          exp_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;

    logic        i8_valid = 1'b0;
    logic        i8_ready;
    logic [7:0]  i8_data = '0;
    logic [2:0]  i8_shamt = '0;
    logic [1:0]  i8_op = '0;
    logic [4:0]  i8_tag = '0;
    logic        o8_valid;
    logic [7:0]  o8_data;
    logic [4:0]  o8_tag;
    logic        o8_busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   presented = 1'b0;
    exp_t sb_q[$];
    vec_t vq[$];

    shift_pipe #(.WIDTH(32), .TAG_W(5)) u_dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(5)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .flush(1'b0),
        .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data),
        .in_shamt(i8_shamt), .in_op(i8_op), .in_tag(i8_tag),
        .out_valid(o8_valid), .out_ready(1'b1), .out_data(o8_data),
        .out_tag(o8_tag), .busy(o8_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                         input logic [4:0] tag, input logic [31:0] exp, input bit push, input bit lat);
        bit   acc;
        int   n;
        exp_t e;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op; in_tag = tag;
        n = 0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; failures++;
            $display("FAIL issue_timeout: tag %0d not accepted within %0d cycles", tag, n);
        end else if (push) begin
            e.dat = exp; e.tag = tag; e.lat_chk = lat;
            // Result shows up after the SHAMT_W-th edge counting the accepting one.
            e.exp_cyc = cyc + SW - 1;
            sb_q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            presented = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_out: out_valid tag %0d data 0x%0h, expected none", out_tag, out_data);
            end else begin
                if (!presented && sb_q[0].lat_chk)
                    check("latency", cyc, sb_q[0].exp_cyc);
                if (out_ready) begin
                    check("out_data", out_data, sb_q[0].dat);
                    check("out_tag", out_tag, sb_q[0].tag);
                    void'(sb_q.pop_front());
                    presented = 1'b0;
                end else begin
                    presented = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        checks++; failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int rises;
        int a;
        int n;
        vec_t v;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed vectors, back-to-back with exact latency
        v = '{32'h8000_0000, 5'd16, 2'b10, 32'hFFFF_8000}; vq.push_back(v);
        v = '{32'h8000_0000, 5'd16, 2'b01, 32'h0000_8000}; vq.push_back(v);
        v = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000}; vq.push_back(v);
        v = '{32'h0000_0001, 5'd1,  2'b11, ROT_EN ? 32'h8000_0000 : 32'h0000_0001}; vq.push_back(v);
        v = '{32'hA5A5_1234, 5'd0,  2'b00, 32'hA5A5_1234}; vq.push_back(v);
        v = '{32'hA5A5_1234, 5'd0,  2'b01, 32'hA5A5_1234}; vq.push_back(v);
        v = '{32'hA5A5_1234, 5'd0,  2'b10, 32'hA5A5_1234}; vq.push_back(v);
        v = '{32'hA5A5_1234, 5'd0,  2'b11, 32'hA5A5_1234}; vq.push_back(v);
        v = '{32'h7000_0000, 5'd4,  2'b10, 32'h0700_0000}; vq.push_back(v);
        v = '{32'h1234_5678, 5'd8,  2'b11, ROT_EN ? 32'h7812_3456 : 32'h1234_5678}; vq.push_back(v);
        v = '{32'hF000_000F, 5'd31, 2'b01, 32'h0000_0001}; vq.push_back(v);
        v = '{32'hDEAD_BEEF, 5'd4,  2'b00, 32'hEADB_EEF0}; vq.push_back(v);
        v = '{32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF}; vq.push_back(v);
        v = '{32'h8000_0001, 5'd31, 2'b11, ROT_EN ? 32'h0000_0003 : 32'h8000_0001}; vq.push_back(v);
        foreach (vq[i])
            issue(vq[i].d, vq[i].sh, vq[i].op, 5'(i + 3), vq[i].exp, 1'b1, 1'b1);
        wait_drain();

        // Streaming tags 0..9 with a 3-cycle consumer stall on tag 2
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue(32'(i) << 8, 5'd4, 2'b01, 5'(i), 32'(i) << 4, 1'b1, 1'b0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!(out_valid && out_tag == 5'd1) && n < 100);
                check("stall_pre_in_ready", in_ready, 1);
                @(posedge clock);
                #1 out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_tag", out_tag, 2);
                    check("stall_data", out_data, 32'h20);
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
                @(negedge clock);
                check("stall_post_in_ready", in_ready, 1);
            end
        join
        wait_drain();

        // Flush with 4 in flight and in_valid high on the flush cycle
        for (int i = 0; i < 4; i++)
            issue(32'h0000_00F0 + 32'(i), 5'd1, 2'b00, 5'(20 + i), 32'h0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'h1111_1111; in_shamt = 5'd0; in_op = 2'b00; in_tag = 5'd30;
        flush = 1'b1;
        @(negedge clock);
        check("preflush_busy", busy, 1);
        @(posedge clock);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("flush_busy", busy, 0);
        rises = 0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) rises++;
        end
        check("flush_no_out", rises, 0);

        // Asynchronous reset pulse between edges with 3 in flight
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++)
            issue(32'h0000_0F00 + 32'(i), 5'd2, 2'b00, 5'(25 + i), 32'h0, 1'b0, 1'b0);
        check("prerst_busy", busy, 1);
        check("prerst_out_data", out_data, 32'h90);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_tag", out_tag, 0);
        #1 reset_n = 1'b1;
        rises = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid || busy) rises++;
        end
        check("postrst_idle", rises, 0);
        @(posedge clock);
        #1;
        issue(32'h0000_0001, 5'd1, 2'b00, 5'd7, 32'h0000_0002, 1'b1, 1'b1);
        wait_drain();

        // 8-bit instance: SRA 0x90 by 3 -> 0xF2 after 3 cycles
        @(negedge clock);
        check("w8_in_ready", i8_ready, 1);
        @(posedge clock);
        #1 i8_valid = 1'b1; i8_data = 8'h90; i8_shamt = 3'd3; i8_op = 2'b10; i8_tag = 5'd21;
        @(posedge clock);
        #1 a = cyc; i8_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!o8_valid && n < 20);
        check("w8_latency", cyc, a + 2);
        check("w8_data", o8_data, 8'hF2);
        check("w8_tag", o8_tag, 21);
        @(negedge clock);
        check("w8_busy_after", o8_busy, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
